tp_sram_wbe: RTL and testbench

Parametrised two-port (1 write, 1 read) synchronous SRAM model with per-byte write enables, selectable 1- or 2-cycle read latency, a read-valid strobe and optional same-address write-to-read forwarding. It is the next-generation memory macro behind the AHB SRAM wrapper. A simultaneous read and write no longer serialise on one port.

---
 rtl/tp_sram_wbe_pkg.sv | 47 ++++
 rtl/tp_sram_wbe_if.sv | 42 ++++
 rtl/tp_sram_wbe_rd_pipe.sv | 38 +++
 rtl/tp_sram_wbe.sv | 137 +++++++++++++
 tb/tb_tp_sram_wbe.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tp_sram_wbe_pkg.sv
// sram_pkg: shared helpers for the tp_sram_wbe two-port SRAM model.
// Optional build macro: SRAM_PARITY_EN (per-byte even parity storage/check).
// Helpers work on a fixed maximum word width; callers size-cast in and out.
package sram_pkg;

    // Widest word the helpers and the read-stage struct can carry.
    localparam int MAX_DW = 1024;
    localparam int MAX_BE = MAX_DW / 8;

    // Number of byte lanes in a word of width dw.
    function automatic int be_w(input int dw);
        return dw / 8;
    endfunction

    // Replace the bytes of old_w selected by be with the bytes of new_w.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] r_w;
        r_w = old_w;
        for (int k = 0; k < MAX_BE; k++) begin
            if (be[k]) begin
                r_w[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return r_w;
    endfunction

    // Even parity of each byte lane: bit k is the XOR of byte k.
    function automatic logic [MAX_BE-1:0] byte_parity(input logic [MAX_DW-1:0] w);
        logic [MAX_BE-1:0] r_p;
        for (int k = 0; k < MAX_BE; k++) begin
            r_p[k] = ^w[8*k +: 8];
        end
        return r_p;
    endfunction

    // One read-pipeline stage; data lanes above the real word width stay zero.
    typedef struct packed {
        logic              valid;
        logic [MAX_DW-1:0] data;
        logic              perr;
    } rd_stage_t;

endpackage

// File: rtl/tp_sram_wbe_if.sv
// tp_sram_wbe_if: write/read bus of the tp_sram_wbe SRAM model.
// Optional build macro: SRAM_PARITY_EN adds perr_inj_i / parity_err_o.
// Handshake: no backpressure. A write commits on any edge with wen_i=1; a read
// is issued on any edge with ren_i=1 and its data is valid exactly in the cycle
// rvalid_o=1, RD_LATENCY edges later; the master must take it in that cycle.
interface tp_sram_wbe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                  wen_i;
    logic [ADDR_BITS-1:0]  waddr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [BE_W-1:0]       wbe_i;
    logic                  ren_i;
    logic [ADDR_BITS-1:0]  raddr_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rvalid_o;
`ifdef SRAM_PARITY_EN
    logic                  perr_inj_i;
    logic                  parity_err_o;

    modport master (
        output wen_i, waddr_i, wdata_i, wbe_i, ren_i, raddr_i, perr_inj_i,
        input  rdata_o, rvalid_o, parity_err_o
    );
    modport slave (
        input  wen_i, waddr_i, wdata_i, wbe_i, ren_i, raddr_i, perr_inj_i,
        output rdata_o, rvalid_o, parity_err_o
    );
`else
    modport master (
        output wen_i, waddr_i, wdata_i, wbe_i, ren_i, raddr_i,
        input  rdata_o, rvalid_o
    );
    modport slave (
        input  wen_i, waddr_i, wdata_i, wbe_i, ren_i, raddr_i,
        output rdata_o, rvalid_o
    );
`endif
endinterface

// File: rtl/tp_sram_wbe_rd_pipe.sv
// sram_rd_pipe: optional extra output register for the SRAM read path.
// EXTRA=0 passes the stage straight through; EXTRA=1 adds one register that
// holds data when no read completes and drops valid/perr in those cycles.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int EXTRA = 0
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  rd_stage_t i_stage,
    output rd_stage_t o_stage
);

    if (EXTRA == 0) begin : g_pass
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk_i ^ rst_n_i;
        assign o_stage = i_stage;
    end else begin : g_reg
        rd_stage_t r_stage;

        // Delay valid/perr by one edge; data only moves when a read completes
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_stage <= '0;
            end else begin
                r_stage.valid <= i_stage.valid;
                r_stage.perr  <= i_stage.valid & i_stage.perr;
                if (i_stage.valid) begin
                    r_stage.data <= i_stage.data;
                end
            end
        end

        assign o_stage = r_stage;
    end

endmodule

// File: rtl/tp_sram_wbe.sv
// tp_sram_wbe: 1-write/1-read synchronous SRAM model with byte enables,
// 1- or 2-cycle read latency, read-valid strobe and optional collision
// forwarding. Optional build macro: SRAM_PARITY_EN (per-byte even parity).
module tp_sram_wbe
    import sram_pkg::*;
#(
    parameter int MEM_DEPTH  = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 10,
    parameter int RD_LATENCY = 1,
    parameter int WR_FWD     = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    tp_sram_wbe_if.slave bus
);

    localparam int BE_W = be_w(DATA_WIDTH);
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(MEM_DEPTH);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("tp_sram_wbe: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
        $error("tp_sram_wbe: DATA_WIDTH must be a multiple of 8 and at most MAX_DW");
    end
    if ((64'd1 << ADDR_BITS) < 64'(MEM_DEPTH)) begin : g_bad_addr
        $error("tp_sram_wbe: ADDR_BITS too small for MEM_DEPTH");
    end

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_perr;

    // Out-of-range addresses drop writes and read back as zero
    assign w_wr_ok = bus.wen_i && ({1'b0, bus.waddr_i} < DEPTH_L);
    assign w_rd_ok = {1'b0, bus.raddr_i} < DEPTH_L;
    assign w_coll  = bus.wen_i && bus.ren_i && w_rd_ok && (bus.waddr_i == bus.raddr_i);

    // Commit each enabled byte of an in-range write
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.wbe_i[k]) begin
                    r_mem[bus.waddr_i][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Pick the word a read captures: array word, forwarded merge, or zero
    always_comb begin
        w_old_word = '0;
        if (w_rd_ok) begin
            w_old_word = r_mem[bus.raddr_i];
        end
        w_rd_word = w_old_word;
        if (w_coll && WR_FWD != 0) begin
            w_rd_word = DATA_WIDTH'(byte_merge(MAX_DW'(w_old_word), MAX_DW'(bus.wdata_i),
                                               MAX_BE'(bus.wbe_i)));
        end
    end

`ifdef SRAM_PARITY_EN
    logic [BE_W-1:0] r_par [MEM_DEPTH];
    logic [BE_W-1:0] w_wr_par;
    logic [BE_W-1:0] w_old_par;

    // Injection flips the stored parity of every byte written this edge
    assign w_wr_par = BE_W'(byte_parity(MAX_DW'(bus.wdata_i))) ^ {BE_W{bus.perr_inj_i}};

    // Store parity only for the enabled bytes, alongside the data
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.wbe_i[k]) begin
                    r_par[bus.waddr_i][k] <= w_wr_par[k];
                end
            end
        end
    end

    // Check array data against stored parity; forwarded data is always clean
    always_comb begin
        w_old_par = '0;
        if (w_rd_ok) begin
            w_old_par = r_par[bus.raddr_i];
        end
        w_rd_perr = w_rd_ok && (BE_W'(byte_parity(MAX_DW'(w_old_word))) != w_old_par);
        if (w_coll && WR_FWD != 0) begin
            w_rd_perr = 1'b0;
        end
    end
`else
    assign w_rd_perr = 1'b0;
`endif

    rd_stage_t r_s1;
    rd_stage_t w_out;

    // First read register: valid every read edge, data held between reads
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= bus.ren_i;
            r_s1.perr  <= bus.ren_i && w_rd_perr;
            if (bus.ren_i) begin
                r_s1.data <= MAX_DW'(w_rd_word);
            end
        end
    end

    sram_rd_pipe #(
        .EXTRA (RD_LATENCY - 1)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_stage (r_s1),
        .o_stage (w_out)
    );

    assign bus.rdata_o  = DATA_WIDTH'(w_out.data);
    assign bus.rvalid_o = w_out.valid;
`ifdef SRAM_PARITY_EN
    assign bus.parity_err_o = w_out.perr;
`else
    logic w_unused_perr;
    assign w_unused_perr = w_out.perr;
`endif

endmodule

// File: tb/tb_tp_sram_wbe.sv
// tb_tp_sram_wbe: directed bench for tp_sram_wbe.
// Two instances share one stimulus stream:
//   dut_a: MEM_DEPTH=1024, RD_LATENCY=1, WR_FWD=1
//   dut_b: MEM_DEPTH=1000, RD_LATENCY=2, WR_FWD=0
// Parity steps are compiled in when SRAM_PARITY_EN is defined.
module tb_tp_sram_wbe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tp_sram_wbe_if #(.DATA_WIDTH(32), .ADDR_BITS(10)) ifa ();
    tp_sram_wbe_if #(.DATA_WIDTH(32), .ADDR_BITS(10)) ifb ();

    assign ifb.wen_i   = ifa.wen_i;
    assign ifb.waddr_i = ifa.waddr_i;
    assign ifb.wdata_i = ifa.wdata_i;
    assign ifb.wbe_i   = ifa.wbe_i;
    assign ifb.ren_i   = ifa.ren_i;
    assign ifb.raddr_i = ifa.raddr_i;
`ifdef SRAM_PARITY_EN
    assign ifb.perr_inj_i = ifa.perr_inj_i;
`endif

    tp_sram_wbe #(
        .MEM_DEPTH(1024), .DATA_WIDTH(32), .ADDR_BITS(10), .RD_LATENCY(1), .WR_FWD(1)
    ) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifa)
    );

    tp_sram_wbe #(
        .MEM_DEPTH(1000), .DATA_WIDTH(32), .ADDR_BITS(10), .RD_LATENCY(2), .WR_FWD(0)
    ) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.wen_i   = 1'b0;
        ifa.waddr_i = '0;
        ifa.wdata_i = '0;
        ifa.wbe_i   = '0;
        ifa.ren_i   = 1'b0;
        ifa.raddr_i = '0;
`ifdef SRAM_PARITY_EN
        ifa.perr_inj_i = 1'b0;
`endif
    endtask

    task automatic set_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        ifa.wen_i   = 1'b1;
        ifa.waddr_i = a;
        ifa.wdata_i = d;
        ifa.wbe_i   = be;
    endtask

    task automatic set_rd(input logic [9:0] a);
        ifa.ren_i   = 1'b1;
        ifa.raddr_i = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        repeat (3) tick();
        chk_bit("rst_a_rvalid", ifa.rvalid_o, 1'b0);
        chk("rst_a_rdata", ifa.rdata_o, 32'h0);
        chk_bit("rst_b_rvalid", ifb.rvalid_o, 1'b0);
        chk("rst_b_rdata", ifb.rdata_o, 32'h0);
`ifdef SRAM_PARITY_EN
        chk_bit("rst_a_perr", ifa.parity_err_o, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Full-word write then read: latency 1 on a, 2 on b
        set_wr(10'd5, 32'hDEADBEEF, 4'hF);
        tick();
        idle();
        set_rd(10'd5);
        tick();
        idle();
        chk_bit("lat_a_valid", ifa.rvalid_o, 1'b1);
        chk("lat_a_data", ifa.rdata_o, 32'hDEADBEEF);
        chk_bit("lat_b_early", ifb.rvalid_o, 1'b0);
        tick();
        chk_bit("lat_a_drop", ifa.rvalid_o, 1'b0);
        chk("lat_a_hold", ifa.rdata_o, 32'hDEADBEEF);
        chk_bit("lat_b_valid", ifb.rvalid_o, 1'b1);
        chk("lat_b_data", ifb.rdata_o, 32'hDEADBEEF);
        tick();
        chk_bit("lat_b_drop", ifb.rvalid_o, 1'b0);
        chk("lat_b_hold", ifb.rdata_o, 32'hDEADBEEF);

        // Partial byte-enable overwrite
        set_wr(10'd7, 32'h11223344, 4'hF);
        tick();
        set_wr(10'd7, 32'hAABBCCDD, 4'b0101);
        tick();
        idle();
        set_rd(10'd7);
        tick();
        idle();
        chk("wbe_a", ifa.rdata_o, 32'h11BB33DD);
        tick();
        chk("wbe_b", ifb.rdata_o, 32'h11BB33DD);

        // Same-edge write/read collision on addr 9
        set_wr(10'd9, 32'h00000000, 4'hF);
        tick();
        set_wr(10'd9, 32'hFFFFFFFF, 4'b0011);
        set_rd(10'd9);
        tick();
        idle();
        set_rd(10'd9);
        chk_bit("coll_a_valid", ifa.rvalid_o, 1'b1);
        chk("coll_a_fwd", ifa.rdata_o, 32'h0000FFFF);
        tick();
        idle();
        chk("coll_a_next", ifa.rdata_o, 32'h0000FFFF);
        chk_bit("coll_b_valid", ifb.rvalid_o, 1'b1);
        chk("coll_b_old", ifb.rdata_o, 32'h00000000);
        tick();
        chk("coll_b_next", ifb.rdata_o, 32'h0000FFFF);

        // Preload addrs 0..7 with value=addr, addr 10 with a marker
        for (int i = 0; i < 8; i++) begin
            set_wr(10'(i), 32'(i), 4'hF);
            tick();
        end
        set_wr(10'd10, 32'h0A0A0A0A, 4'hF);
        tick();
        idle();
        tick();

        // Streaming reads, one per cycle
        for (int i = 0; i < 8; i++) begin
            set_rd(10'(i));
            tick();
            chk_bit("strm_a_valid", ifa.rvalid_o, 1'b1);
            chk("strm_a_data", ifa.rdata_o, 32'(i));
            if (i > 0) begin
                chk_bit("strm_b_valid", ifb.rvalid_o, 1'b1);
                chk("strm_b_data", ifb.rdata_o, 32'(i - 1));
            end else begin
                chk_bit("strm_b_first", ifb.rvalid_o, 1'b0);
            end
        end
        idle();
        tick();
        chk_bit("strm_a_end", ifa.rvalid_o, 1'b0);
        chk_bit("strm_b_last_valid", ifb.rvalid_o, 1'b1);
        chk("strm_b_last_data", ifb.rdata_o, 32'd7);
        tick();
        chk_bit("strm_b_end", ifb.rvalid_o, 1'b0);

        // Addr 1010: in range for a, out of range for b
        set_wr(10'd1010, 32'hCAFEF00D, 4'hF);
        tick();
        idle();
        set_rd(10'd1010);
        tick();
        idle();
        set_rd(10'd10);
        chk("oor_a_data", ifa.rdata_o, 32'hCAFEF00D);
        tick();
        idle();
        set_rd(10'd7);
        chk_bit("oor_b_valid", ifb.rvalid_o, 1'b1);
        chk("oor_b_zero", ifb.rdata_o, 32'h0);
        tick();
        idle();
        chk("oor_b_addr10", ifb.rdata_o, 32'h0A0A0A0A);
        tick();
        chk("oor_b_addr7", ifb.rdata_o, 32'd7);

        // Reset while b's read is still in flight
        set_rd(10'd3);
        tick();
        idle();
        chk("mid_a_data", ifa.rdata_o, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_bit("mid_a_valid", ifa.rvalid_o, 1'b0);
        chk("mid_a_clear", ifa.rdata_o, 32'h0);
        chk_bit("mid_b_valid", ifb.rvalid_o, 1'b0);
        chk("mid_b_clear", ifb.rdata_o, 32'h0);
        tick();
        chk_bit("mid_b_valid2", ifb.rvalid_o, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_bit("mid_b_after", ifb.rvalid_o, 1'b0);
        chk("mid_b_after_data", ifb.rdata_o, 32'h0);
        set_rd(10'd3);
        tick();
        idle();
        chk("persist_a", ifa.rdata_o, 32'd3);
        tick();
        chk("persist_b", ifb.rdata_o, 32'd3);

`ifdef SRAM_PARITY_EN
        // Injected parity error, then clean rewrite
        set_wr(10'd3, 32'h12345678, 4'hF);
        ifa.perr_inj_i = 1'b1;
        tick();
        idle();
        set_rd(10'd3);
        tick();
        idle();
        chk_bit("par_a_valid", ifa.rvalid_o, 1'b1);
        chk_bit("par_a_err", ifa.parity_err_o, 1'b1);
        tick();
        chk_bit("par_a_err_drop", ifa.parity_err_o, 1'b0);
        chk_bit("par_b_err", ifb.parity_err_o, 1'b1);
        set_wr(10'd3, 32'h12345678, 4'hF);
        tick();
        idle();
        set_rd(10'd3);
        tick();
        idle();
        chk_bit("par_a_clean_valid", ifa.rvalid_o, 1'b1);
        chk_bit("par_a_clean", ifa.parity_err_o, 1'b0);
        tick();
        chk_bit("par_b_clean", ifb.parity_err_o, 1'b0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
